logic_8_bits_arbiter: RTL and testbench
=======================================

# logic_8_bits_arbiter

Shares one 8-bit logic/arithmetic unit between two requesters. Each requester presents an operation and two 8-bit operands over a valid/ready handshake. The arbiter grants round-robin, executes the operation in a registered stage, and returns the result on a single shared response channel tagged with the requester id. It sits in front of the 8-bit OR/AND datapath and is the only path by which other blocks use it.

## Interface
- No parameters; all widths fixed at 8 bits.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
- req0_a, req0_b  input  8 each  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that issued the result.
- rsp_data  output  8  result.
- rsp_carry  output  1  carry out of ADD; 0 for other opcodes.
- op_count  output  8  number of completed responses, wraps modulo 256.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid is high, select a grant.
  - The granted reqN_ready goes high combinationally in the same cycle.
  - On the rising edge, latch op, a, b and id, then move to EXEC.
- Grant rule:
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester not equal to last_grant.
  - last_grant updates on every acceptance and resets to 1, so requester 0 wins the first tie.
- EXEC:
  - Compute from the latched operands: AND, OR and XOR are bitwise.
  - ADD is a 9-bit sum; rsp_data takes bits [7:0] and rsp_carry takes bit 8.
  - Register the result and move to RESP unconditionally.
- RESP:
  - rsp_valid is high; rsp_id, rsp_data and rsp_carry are stable.
  - On an edge with rsp_ready high: op_count increments (255 wraps to 0) and the state moves to IDLE.
  - Otherwise hold RESP with outputs unchanged.
- Both reqN_ready are 0 in EXEC and RESP. A requester may drop valid before acceptance without effect.
- An operation is never accepted while a response is outstanding; there is one operation in flight at most.

## Timing
- Reset values:
  - req0_ready and req1_ready are 0 while reset is asserted.
  - rsp_valid, rsp_id, rsp_data, rsp_carry and op_count are all 0.
  - last_grant is 1 and the state is IDLE.
- Latency: acceptance at edge E0 puts the FSM in EXEC. Edge E0+1 registers the result and raises rsp_valid. The earliest response transfer is edge E0+2.
- Throughput: with rsp_ready held high, at most one operation per 3 cycles.
- The next acceptance can occur in the cycle after the response transfer (IDLE cycle).
- Reset asserted mid-operation, in EXEC or RESP:
  - Return immediately to IDLE and drop rsp_valid asynchronously.
  - The in-flight operation is lost and op_count clears.
- The response registers change only on the EXEC→RESP edge. The request inputs are not sampled after acceptance.

## Test plan
- Single OR from requester 0:
  - Stimulus: a=8'b10011101, b=8'b10011111.
  - Response: rsp_valid 2 cycles after acceptance, rsp_data=8'b10011111, rsp_carry=0, rsp_id=0, op_count=1.
- ADD overflow from requester 1:
  - Stimulus: a=8'hFF, b=8'h01.
  - Response: rsp_data=8'h00, rsp_carry=1, rsp_id=1.
- Fairness:
  - Stimulus: both requesters valid continuously, 4 operations.
  - Response: grants alternate 0,1,0,1; each reqN_ready is a single-cycle pulse; rsp_id follows the same order.
- Backpressure:
  - Stimulus: rsp_ready held low 5 cycles in RESP with req0_valid high.
  - Response: rsp_valid and rsp_data stable throughout, req0_ready stays 0, op_count unchanged until the transfer edge.
- Reset mid-operation:
  - Stimulus: assert reset while in EXEC with an AND of 8'hF0 and 8'h3C in flight.
  - Response: rsp_valid never rises, all outputs 0, and the first operation after reset completes normally.
- Counter wrap:
  - Stimulus: 256 back-to-back XOR operations (a=8'hAA, b=8'h55).
  - Response: every rsp_data=8'hFF; op_count reads 255 after the 255th response and 0 after the 256th.

Source files
------------

// File: rtl/logic_8_bits_arbiter.sv
// Round-robin arbiter that shares one 8-bit AND/OR/XOR/ADD unit between two requesters.
// The unit runs one operation at a time and returns it on a shared response channel tagged with the requester id.
`timescale 1ns/1ps
module logic_8_bits_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] op_count_q, op_count_d;
    logic       grant_id;
    logic [8:0] sum;

    // NOTE: every signal driven here gets a default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        grant_id     = 1'b0;
        sum          = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester that did not win last time is served.
                    grant_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    req0_ready   = ~grant_id & ~reset;
                    req1_ready   = grant_id & ~reset;
                    op_d         = grant_id ? op_t'(req1_op) : op_t'(req0_op);
                    a_d          = grant_id ? req1_a : req0_a;
                    b_d          = grant_id ? req1_b : req0_b;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d    = id_q;
                rsp_carry_d = 1'b0;
                case (op_q)
                    OP_AND:  rsp_data_d = a_q & b_q;
                    OP_OR:   rsp_data_d = a_q | b_q;
                    OP_XOR:  rsp_data_d = a_q ^ b_q;
                    default: {rsp_carry_d, rsp_data_d} = sum;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_AND;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= 8'd0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            op_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_id_q     <= rsp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_8_bits_arbiter.sv
// Directed bench for logic_8_bits_arbiter: single ops, ADD carry, fairness, backpressure,
// reset mid-operation and op_count wrap, all with hand-computed expected values.
`timescale 1ns/1ps
module tb_logic_8_bits_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [7:0] rsp_data, op_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_count = 8'd0;

    logic_8_bits_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One full operation with rsp_ready high: accept, EXEC, RESP, transfer.
    task automatic do_op(input logic id, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_data, input logic exp_carry);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        check("accept_ready", id ? req1_ready : req0_ready, 1);
        check("other_ready", id ? req0_ready : req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_carry", rsp_carry, exp_carry);
        @(posedge clk);
        exp_count = exp_count + 8'd1;
        #1;
        check("op_count", op_count, exp_count);
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'd0; req0_b = 8'd0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'd0; req1_b = 8'd0;
        rsp_ready = 1'b0;

        // Reset state, with both requesters asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outputs", {rsp_id, rsp_carry, rsp_data, op_count}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;

        // Single OR from requester 0, then ADD overflow from requester 1.
        do_op(1'b0, 2'b01, 8'b10011101, 8'b10011111, 8'b10011111, 1'b0);
        check("or_count_is_1", op_count, 1);
        do_op(1'b1, 2'b11, 8'hFF, 8'h01, 8'h00, 1'b1);

        // Fairness: both valid continuously; last grant was 1, so order is 0,1,0,1.
        @(negedge clk);
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h0F; req0_b = 8'h3C;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'h0F; req1_b = 8'h30;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            check("fair_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
            @(posedge clk);
            @(negedge clk);
            check("fair_pulse", {req0_ready, req1_ready}, 0);
            @(posedge clk);
            @(negedge clk);
            check("fair_rsp_id", rsp_id, k % 2);
            check("fair_rsp_data", rsp_data, (k % 2 == 1) ? 8'h3F : 8'h0C);
            @(posedge clk);
            exp_count = exp_count + 8'd1;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("fair_count", op_count, exp_count);

        // Backpressure: hold rsp_ready low 5 cycles in RESP with req0_valid high.
        @(negedge clk);
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check("bp_accept", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_a = 8'h00;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'h26);
            check("bp_ready0", req0_ready, 0);
            check("bp_count", op_count, exp_count);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        exp_count = exp_count + 8'd1;
        #1;
        check("bp_count_after", op_count, exp_count);
        check("bp_rsp_valid_drop", rsp_valid, 0);
        @(negedge clk);
        req0_valid = 1'b0;

        // Reset while an AND is in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'hF0; req0_b = 8'h3C;
        #1;
        check("mid_accept", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_outputs", {rsp_id, rsp_carry, rsp_data, op_count}, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_hold_valid", rsp_valid, 0);
        end
        reset = 1'b0;
        exp_count = 8'd0;
        do_op(1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);

        // Counter wrap: fresh reset, then 256 back-to-back XORs.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 8'd0;
        for (int n = 1; n <= 256; n++) begin
            do_op(1'b0, 2'b10, 8'hAA, 8'h55, 8'hFF, 1'b0);
            if (n == 255) check("wrap_255", op_count, 255);
            if (n == 256) check("wrap_0", op_count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
